fc_dot_seq: RTL and testbench
=============================

# fc_dot_seq

Sequential dot-product engine for the fully-connected layer. It accepts one signed operand pair (a, b) per cycle over a valid/ready stream and accumulates K products. Each finished K-element dot product is presented on a registered valid/ready output. It sits directly upstream of the layer's activation/requantisation stage and computes the same multiply-accumulate as the combinational MAC, time-multiplexed over K cycles.

## Interface
- N, 8, operand bit-width (signed two's complement)
- K, 3, vector dimension (elements per dot product), K >= 1
- L, 2*(N-1)+K, accumulator/result bit-width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  a/b hold a valid element
- in_ready  output  1  block accepts the element this cycle
- a  input  N  signed operand A
- b  input  N  signed operand B
- out_valid  output  1  s holds a completed dot product
- out_ready  input  1  consumer takes s this cycle
- s  output  L  signed dot product, registered

## Operation
- Element accept: in_valid && in_ready at a rising edge.
- Product: p = a*b at full precision (2N bits), sign-extended or truncated to L bits.
- Element counter cnt, range 0..K-1:
  - On accept, acc <= (cnt==0 ? 0 : acc) + p.
  - cnt increments on accept and wraps to 0 after K-1.
  - cnt==0 means "start of vector". The first element overwrites acc; no separate clear cycle is needed.
- Arithmetic is modulo 2^L (two's-complement wrap), with no saturation and no overflow flag. With default parameters no wrap is possible (|sum| <= K*2^(2N-2) < 2^(L-1)).
- Completion: an accept with cnt==K-1 loads s <= acc_next (the sum including the current product) and sets out_valid=1 on the next cycle.
- Output drain: out_valid && out_ready clears out_valid, unless a completion happens the same cycle. In that case out_valid stays 1 and s takes the new value.
- in_ready = !rst && (cnt != K-1 || !out_valid || out_ready):
  - Non-final elements are always accepted; accumulation of the next vector overlaps a pending output.
  - A final element is accepted only if the output register is empty or draining this cycle.
  - in_ready depends combinationally on out_ready. in_ready does not depend on in_valid.
- s is stable while out_valid=1 and out_ready=0.
- in_valid may be deasserted between elements at any time; gaps do not affect the result.
- Elements are consumed strictly in order; there is no vector framing input. Vector boundaries are defined solely by the count.
- K=1: every accept is a completion; acc is unused.

## Timing
- Reset, sampled on a rising edge, forces: cnt=0, acc=0, s=0, out_valid=0. in_ready=0 while rst is high and 1 on the first cycle after rst deasserts.
- Reset mid-vector discards the partial sum. Reset with out_valid=1 discards the pending result.
- Latency: out_valid rises 1 cycle after the accept of element K-1.
- Throughput: 1 element/cycle with out_ready held high. This gives one result every K cycles and never deasserts in_ready.
- Backpressure: with out_ready=0 and a result pending, the next vector's elements 0..K-2 are still accepted. in_ready drops while cnt==K-1 and resumes in the same cycle out_ready=1.
- Simultaneous drain and completion (out_ready=1, final accept): s updates to the new sum and out_valid stays 1, so there is no bubble.

## Test plan
- Basic (N=8, K=3, out_ready=1): a=(1,2,3), b=(4,5,6) on 3 consecutive cycles -> out_valid 1 cycle after the 3rd accept with s=32, asserted for exactly 1 cycle.
- Signed extremes: a=b=(-128,-128,-128) -> s=49152. Then a=(127,-128,5), b=(-128,-128,-3) -> s=113. Both back-to-back with no idle cycle between vectors.
- Backpressure: hold out_ready=0 after the first result (32).
  - Send a=(1,1,1), b=(1,1,1): elements 0 and 1 are accepted; in_ready=0 on element 2.
  - s stays 32.
  - Raise out_ready for 1 cycle -> 32 consumed, element 2 accepted in the same cycle, next cycle s=3 with out_valid=1.
- Input gaps: a=(2,3,4), b=(5,6,7), with in_valid low for 2 cycles between each element -> s=56. No result is produced before the 3rd accept.
- Reset mid-vector: accept 2 elements (10·10, 10·10), pulse rst for 1 cycle -> out_valid=0, s=0. Then a=(1,0,0), b=(7,0,0) -> s=7, with no contamination from the partial sum of 200.
- K=1 configuration (N=8, L=15): stream a=(3,-4,127), b=(5,6,-128) -> s=15, -24, -16256 on consecutive cycles, out_valid continuously high.

Source files
------------

// File: rtl/fc_dot_seq.sv
// fc_dot_seq: sequential K-element signed dot product with registered valid/ready result.
module fc_dot_seq #(
  parameter int N = 8,
  parameter int K = 3,
  parameter int L = 2*(N-1)+K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [L-1:0] s
);
  localparam int CW = K > 1 ? $clog2(K) : 1;
  logic [CW-1:0] cnt;
  logic [L-1:0]  acc, acc_next, p;
  logic          last, acc_en;
  // Sign-extending both operands to L bits yields the full product modulo 2^L.
  always_comb begin
    p        = L'($signed(a)) * L'($signed(b));
    last     = cnt == CW'(K-1);
    in_ready = !rst && (!last || !out_valid || out_ready);
    acc_en   = in_valid && in_ready;
    acc_next = (cnt == '0 ? '0 : acc) + p;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      s         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (acc_en) begin
        acc <= acc_next;
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (acc_en && last) begin
        s         <= acc_next;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fc_dot_seq.sv
// tb_fc_dot_seq: directed checks of the dot-product engine for K=3 and K=1.
module tb_fc_dot_seq;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [7:0] a, b;
  logic signed [16:0] s;
  logic in_valid1, in_ready1, out_valid1, out_ready1;
  logic signed [7:0] a1, b1;
  logic signed [14:0] s1;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fc_dot_seq #(.N(8), .K(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .s(s)
  );

  fc_dot_seq #(.N(8), .K(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .s(s1)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic el(input string tag, input int x, input int y);
    a = 8'(x);
    b = 8'(y);
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_s", s, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    el("basic0", 1, 4);
    el("basic1", 2, 5);
    chk("basic_no_early", 32'(out_valid), 0);
    el("basic2", 3, 6);
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_s", s, 32);
    idle(1);
    chk("basic_one_cycle", 32'(out_valid), 0);

    el("ext0", -128, -128);
    el("ext1", -128, -128);
    el("ext2", -128, -128);
    chk("ext_valid", 32'(out_valid), 1);
    chk("ext_s", s, 49152);
    el("mix0", 127, -128);
    el("mix1", -128, -128);
    el("mix2", 5, -3);
    chk("mix_valid", 32'(out_valid), 1);
    chk("mix_s", s, 113);
    idle(1);

    out_ready = 1'b0;
    el("bp_r0", 1, 4);
    el("bp_r1", 2, 5);
    el("bp_r2", 3, 6);
    chk("bp_first_s", s, 32);
    el("bp0", 1, 1);
    el("bp1", 1, 1);
    a = 8'sd1; b = 8'sd1; in_valid = 1'b1;
    #1;
    chk("bp_blocked", 32'(in_ready), 0);
    tick();
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_s", s, 32);
    out_ready = 1'b1;
    #1;
    chk("bp_resume", 32'(in_ready), 1);
    tick();
    chk("bp_new_valid", 32'(out_valid), 1);
    chk("bp_new_s", s, 3);
    idle(1);
    chk("bp_drained", 32'(out_valid), 0);

    el("gap0", 2, 5);
    idle(2);
    el("gap1", 3, 6);
    idle(2);
    chk("gap_no_early", 32'(out_valid), 0);
    el("gap2", 4, 7);
    chk("gap_valid", 32'(out_valid), 1);
    chk("gap_s", s, 56);
    idle(1);

    el("mid0", 10, 10);
    el("mid1", 10, 10);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_s", s, 0);
    rst = 1'b0;
    el("clean0", 1, 7);
    el("clean1", 0, 0);
    el("clean2", 0, 0);
    chk("clean_valid", 32'(out_valid), 1);
    chk("clean_s", s, 7);
    idle(1);

    in_valid1 = 1'b1;
    a1 = 8'sd3; b1 = 8'sd5;
    tick();
    chk("k1_v0", 32'(out_valid1), 1);
    chk("k1_s0", s1, 15);
    a1 = -8'sd4; b1 = 8'sd6;
    tick();
    chk("k1_v1", 32'(out_valid1), 1);
    chk("k1_s1", s1, -24);
    a1 = 8'sd127; b1 = -8'sd128;
    #1;
    chk("k1_in_ready", 32'(in_ready1), 1);
    tick();
    chk("k1_v2", 32'(out_valid1), 1);
    chk("k1_s2", s1, -16256);
    a1 = -8'sd128; b1 = -8'sd128;
    tick();
    chk("k1_wrap", s1, -16384);
    in_valid1 = 1'b0;
    tick();
    chk("k1_drained", 32'(out_valid1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
